// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_pkg;

    localparam int REG_IDX_W = 5;
    localparam int WAIT_W    = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic                 mem_read_ex,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 use_rs1_id,
    input  logic                 use_rs2_id,
    output logic                 hazard
);

    // x0 is never a real producer, so a load into x0 cannot create a hazard
    always_comb begin
        hazard = mem_read_ex && (rd_ex != '0) &&
                 ((use_rs1_id && (rs1_id == rd_ex)) ||
                  (use_rs2_id && (rs2_id == rd_ex)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer; HAZARD_PERF_EN enables perf counters
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memRead_EX,
    input  logic [REG_IDX_W-1:0] rd_EX,
    input  logic [REG_IDX_W-1:0] rs1_ID,
    input  logic [REG_IDX_W-1:0] rs2_ID,
    input  logic                 useRs1_ID,
    input  logic                 useRs2_ID,
    input  logic                 branchTaken_EX,
    input  logic                 memReq_MEM,
    input  logic                 memReady_MEM,
    output logic                 pcWrite,
    output logic                 ifIdWrite,
    output logic                 ifIdFlush,
    output logic                 idExWrite,
    output logic                 idExFlush,
    output logic                 exMemWrite,
    output logic                 memWbBubble,
    output logic                 memTimeout,
    output logic [CNT_W-1:0]     stallCycles,
    output logic [CNT_W-1:0]     flushCount
);

    hazard_state_t     state_q;
    hazard_state_t     state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              load_use;
    logic              wait_expired;
    pipe_ctrl_t        ctrl;

    assign mem_stall    = memReq_MEM && !memReady_MEM;
    assign wait_expired = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

    load_use_detect u_load_use_detect (
        .mem_read_ex (memRead_EX),
        .rd_ex       (rd_EX),
        .rs1_id      (rs1_ID),
        .rs2_id      (rs2_ID),
        .use_rs1_id  (useRs1_ID),
        .use_rs2_id  (useRs2_ID),
        .hazard      (load_use)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts consecutive memory-stalled cycles; cleared whenever memory is not stalling
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if ((state_q != ERROR) && mem_stall) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state: enter MEM_WAIT on a stall, leave on release, trap on timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d = RUN;
                end else if (wait_expired) begin
                    state_d = ERROR;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Mealy outputs: priority is error, memory stall, branch flush, load-use
    always_comb begin
        ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                 id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                 mem_wb_bubble: 1'b0};
        if (state_q == ERROR) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_write   = 1'b0;
            ctrl.ex_mem_write  = 1'b0;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (mem_stall) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_write   = 1'b0;
            ctrl.ex_mem_write  = 1'b0;
            ctrl.mem_wb_bubble = 1'b1;
        end else if (branchTaken_EX) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_flush   = 1'b1;
        end else if (load_use) begin
            ctrl.pc_write      = 1'b0;
            ctrl.if_id_write   = 1'b0;
            ctrl.id_ex_flush   = 1'b1;
        end
    end

    assign pcWrite     = ctrl.pc_write;
    assign ifIdWrite   = ctrl.if_id_write;
    assign ifIdFlush   = ctrl.if_id_flush;
    assign idExWrite   = ctrl.id_ex_write;
    assign idExFlush   = ctrl.id_ex_flush;
    assign exMemWrite  = ctrl.ex_mem_write;
    assign memWbBubble = ctrl.mem_wb_bubble;
    assign memTimeout  = (state_q == ERROR);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating perf counters for frozen-PC cycles and branch flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (ctrl.if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign stallCycles = stall_cnt;
    assign flushCount  = flush_cnt;
`else
    assign stallCycles = '0;
    assign flushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CNT_W = 16;
`ifdef HAZARD_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             memRead_EX = 1'b0;
    logic [4:0]       rd_EX = '0;
    logic [4:0]       rs1_ID = '0;
    logic [4:0]       rs2_ID = '0;
    logic             useRs1_ID = 1'b0;
    logic             useRs2_ID = 1'b0;
    logic             branchTaken_EX = 1'b0;
    logic             memReq_MEM = 1'b0;
    logic             memReady_MEM = 1'b0;
    logic             pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush;
    logic             exMemWrite, memWbBubble, memTimeout;
    logic [CNT_W-1:0] stallCycles, flushCount;

    int pass_cnt = 0;
    int total_cnt = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .memRead_EX(memRead_EX), .rd_EX(rd_EX),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .useRs1_ID(useRs1_ID), .useRs2_ID(useRs2_ID),
        .branchTaken_EX(branchTaken_EX),
        .memReq_MEM(memReq_MEM), .memReady_MEM(memReady_MEM),
        .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
        .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
        .memWbBubble(memWbBubble), .memTimeout(memTimeout),
        .stallCycles(stallCycles), .flushCount(flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: error flag plus length of the current run of stalled cycles
    bit m_err = 1'b0;
    int m_run = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub;

    always_comb begin
        bit st, lu;
        st = memReq_MEM && !memReady_MEM;
        lu = memRead_EX && (rd_EX != 0) &&
             ((useRs1_ID && rs1_ID == rd_EX) || (useRs2_ID && rs2_ID == rd_EX));
        {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub} = 7'b1101010;
        if (m_err || st) begin
            {e_pc, e_ifw, e_iff, e_idw, e_idf, e_exw, e_bub} = 7'b0000001;
        end else if (branchTaken_EX) begin
            e_iff = 1'b1;
            e_idf = 1'b1;
        end else if (lu) begin
            e_pc  = 1'b0;
            e_ifw = 1'b0;
            e_idf = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_err   <= 1'b0;
            m_run   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (!e_pc)  m_stall <= (m_stall + 1 > 2**CNT_W - 1) ? 2**CNT_W - 1 : m_stall + 1;
            if (e_iff)  m_flush <= (m_flush + 1 > 2**CNT_W - 1) ? 2**CNT_W - 1 : m_flush + 1;
            if (!m_err && memReq_MEM && !memReady_MEM) begin
                m_run <= m_run + 1;
                if (m_run + 1 >= TO) m_err <= 1'b1;
            end else begin
                m_run <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_pcWrite",     int'(pcWrite),     int'(e_pc));
        chk("m_ifIdWrite",   int'(ifIdWrite),   int'(e_ifw));
        chk("m_ifIdFlush",   int'(ifIdFlush),   int'(e_iff));
        chk("m_idExWrite",   int'(idExWrite),   int'(e_idw));
        chk("m_idExFlush",   int'(idExFlush),   int'(e_idf));
        chk("m_exMemWrite",  int'(exMemWrite),  int'(e_exw));
        chk("m_memWbBubble", int'(memWbBubble), int'(e_bub));
        chk("m_memTimeout",  int'(memTimeout),  int'(m_err));
        chk("m_stallCycles", int'(stallCycles), PERF * m_stall);
        chk("m_flushCount",  int'(flushCount),  PERF * m_flush);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit mr, input int rd, input int r1, input int r2,
                         input bit u1, input bit u2, input bit br, input bit req, input bit rdy);
        memRead_EX     = mr;
        rd_EX          = 5'(rd);
        rs1_ID         = 5'(r1);
        rs2_ID         = 5'(r2);
        useRs1_ID      = u1;
        useRs2_ID      = u2;
        branchTaken_EX = br;
        memReq_MEM     = req;
        memReady_MEM   = rdy;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        idle();
        chk("rst_pcWrite", int'(pcWrite), 1);
        chk("rst_memTimeout", int'(memTimeout), 0);
        chk("rst_stallCycles", int'(stallCycles), 0);

        // load-use on rs1
        drive(1, 5, 5, 0, 1, 0, 0, 0, 0);
        chk("lu_pcWrite", int'(pcWrite), 0);
        chk("lu_ifIdWrite", int'(ifIdWrite), 0);
        chk("lu_idExFlush", int'(idExFlush), 1);
        tick();
        drive(0, 0, 5, 0, 1, 0, 0, 0, 0);
        chk("lu_after_pcWrite", int'(pcWrite), 1);
        tick();
        // rd = x0 never stalls
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("lu_x0_pcWrite", int'(pcWrite), 1);
        tick();
        // rs2 match, then same register not actually used
        drive(1, 7, 3, 7, 1, 1, 0, 0, 0);
        chk("lu_rs2_pcWrite", int'(pcWrite), 0);
        tick();
        drive(1, 7, 3, 7, 1, 0, 0, 0, 0);
        chk("lu_rs2_unused_pcWrite", int'(pcWrite), 1);
        tick();

        // branch overrides load-use
        do_reset();
        drive(1, 5, 5, 0, 1, 0, 1, 0, 0);
        chk("br_ifIdFlush", int'(ifIdFlush), 1);
        chk("br_idExFlush", int'(idExFlush), 1);
        chk("br_pcWrite", int'(pcWrite), 1);
        tick();
        idle();
        chk("br_flushCount", int'(flushCount), PERF);

        // three-cycle memory stall
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ms_pcWrite", int'(pcWrite), 0);
            chk("ms_exMemWrite", int'(exMemWrite), 0);
            chk("ms_memWbBubble", int'(memWbBubble), 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("ms_rel_pcWrite", int'(pcWrite), 1);
        chk("ms_rel_memWbBubble", int'(memWbBubble), 0);
        chk("ms_stallCycles", int'(stallCycles), 3 * PERF);
        tick();

        // branch held during a stall flushes only on release
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("bs_ifIdFlush", int'(ifIdFlush), 0);
        tick();
        chk("bs_ifIdFlush2", int'(ifIdFlush), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("bs_rel_ifIdFlush", int'(ifIdFlush), 1);
        chk("bs_rel_pcWrite", int'(pcWrite), 1);
        tick();

        // reset in the middle of MEM_WAIT
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("rw_pcWrite", int'(pcWrite), 1);
        chk("rw_idExWrite", int'(idExWrite), 1);
        chk("rw_stallCycles", int'(stallCycles), 0);
        chk("rw_flushCount", int'(flushCount), 0);

        // timeout into ERROR after TO stalled cycles
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= TO; i++) begin
            tick();
            chk("to_memTimeout", int'(memTimeout), (i == TO) ? 1 : 0);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        tick();
        chk("err_memTimeout", int'(memTimeout), 1);
        chk("err_pcWrite", int'(pcWrite), 0);
        chk("err_ifIdFlush", int'(ifIdFlush), 0);
        chk("err_stallCycles", int'(stallCycles), (TO + 1) * PERF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        chk("err_rst_memTimeout", int'(memTimeout), 0);
        chk("err_rst_pcWrite", int'(pcWrite), 1);
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
